// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Command-stream to APB initiator. A small command FIFO feeds a three-state
// APB FSM; a wait-state counter forces an error completion when the slave
// stalls too long, so the bus is never held forever.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | bus idle, waiting for a queued command
// S_SETUP  | APB setup phase (psel=1, penable=0)
// S_ACCESS | APB access phase (psel=1, penable=1), waiting on pready
module apb_master_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic              rsp_write_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int ENT_W  = 1 + ADDR_W + DATA_W;

   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   state_t            state_q, state_d;
   logic [WCNT_W-1:0] wait_q, wait_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              pwrite_q, pwrite_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic              timed_out;
   logic [ENT_W-1:0]  head;

   assign cmd_ready_o = (count_q != FULL_CNT);
   assign push        = cmd_valid_i & cmd_ready_o;
   assign fifo_empty  = (count_q == '0);
   assign head        = fifo_mem[rd_ptr_q];
   assign timed_out   = (TIMEOUT != 0) && (wait_q == WAIT_MAX);

   // Command storage; entries need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i};
      end
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO control registers.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // APB sequencing and response formation; every bus/response output is a flop.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      pop         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               pwrite_d  = head[ENT_W-1];
               paddr_d   = head[ADDR_W+DATA_W-1:DATA_W];
               pwdata_d  = head[DATA_W-1:0];
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = S_SETUP;
            end
         end

         S_SETUP: begin
            penable_d = 1'b1;
            wait_d    = '0;
            state_d   = S_ACCESS;
         end

         S_ACCESS: begin
            if (pready_i || timed_out) begin
               rsp_valid_d = 1'b1;
               rsp_write_d = pwrite_q;
               rsp_err_d   = ~pready_i;
               rsp_rdata_d = (pready_i && !pwrite_q) ? prdata_i : '0;
               penable_d   = 1'b0;
               if (!fifo_empty) begin
                  // Back-to-back: psel stays high straight into the next setup.
                  pop      = 1'b1;
                  pwrite_d = head[ENT_W-1];
                  paddr_d  = head[ADDR_W+DATA_W-1:DATA_W];
                  pwdata_d = head[DATA_W-1:0];
                  psel_d   = 1'b1;
                  state_d  = S_SETUP;
               end else begin
                  psel_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else begin
               wait_d = wait_q + WCNT_W'(1);
            end
         end

         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs; reset aborts any bus cycle in flight.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;
   assign pwrite_o    = pwrite_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_write_o = rsp_write_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed latency/ordering/timeout/reset
// scenarios followed by randomized traffic, with a register-array reference
// model, a wait-state driven APB slave and a decoupled scoreboard monitor.
module tb_apb_master_bridge;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int TMO   = 255;
   localparam int STUCK = 300;

   logic          clk = 1'b0;
   logic          rst_ = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready_o;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid_o;
   logic          rsp_write_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic [AW-1:0] paddr_o;
   logic [DW-1:0] pwdata_o;
   logic          psel_o;
   logic          penable_o;
   logic          pwrite_o;
   logic [DW-1:0] prdata = '0;
   logic          pready = 1'b0;

   always #5 clk = ~clk;

   apb_master_bridge #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_(rst_),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid_o), .rsp_write_o(rsp_write_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .psel_o(psel_o),
      .penable_o(penable_o), .pwrite_o(pwrite_o),
      .prdata_i(prdata), .pready_i(pready)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      int          acc_cyc;
      int          lat;
   } exp_t;

   exp_t        rsp_q[$];
   exp_t        setup_q[$];
   int          wait_q[$];
   logic [31:0] ref_mem [16];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          psel_run = 0;
   int          last_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] init_val(input int i);
      return (i == 1) ? 32'h1234_5678 : 32'h1111_1111 * i;
   endfunction

   // APB slave: register array, completes after the wait count queued for this transfer.
   logic [31:0] slv_mem [16];
   bit          slv_init = 0;
   int          acc_n = 0;
   int          cur_w = 0;
   always @(negedge clk) begin
      if (!slv_init) begin
         for (int i = 0; i < 16; i++) slv_mem[i] = init_val(i);
         slv_init = 1;
      end
      if (!rst_) begin
         wait_q.delete();
         pready = 1'b0;
         prdata = '0;
      end else if (psel_o && !penable_o) begin
         acc_n = 0;
         cur_w = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
         pready = 1'b0;
      end else if (psel_o && penable_o) begin
         if (acc_n == cur_w) begin
            pready = 1'b1;
            if (pwrite_o) slv_mem[paddr_o[5:2]] = pwdata_o;
            else          prdata = slv_mem[paddr_o[5:2]];
         end else begin
            pready = 1'b0;
            prdata = $urandom;
         end
         acc_n++;
      end else begin
         pready = 1'($urandom_range(0, 1));
         prdata = $urandom;
      end
   end

   // Scoreboard monitor: checks each setup phase and each response against the queues.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_) begin
         rsp_q.delete();
         setup_q.delete();
         psel_run = 0;
      end else begin
         if (psel_o) psel_run++;
         else begin
            if (psel_run > 0) last_run = psel_run;
            psel_run = 0;
         end
         if (penable_o && !psel_o) fail("penable_without_psel");
         if (psel_o && !penable_o) begin
            if (setup_q.size() == 0) fail("unexpected_setup");
            else begin
               e = setup_q.pop_front();
               chk("setup_paddr", paddr_o, e.addr);
               chk("setup_pwrite", 32'(pwrite_o), 32'(e.wr));
               if (e.wr) chk("setup_pwdata", pwdata_o, e.wdata);
            end
         end
         if (rsp_valid_o) begin
            if (rsp_q.size() == 0) fail("unexpected_response");
            else begin
               e = rsp_q.pop_front();
               chk("rsp_write", 32'(rsp_write_o), 32'(e.wr));
               chk("rsp_rdata", rsp_rdata_o, e.rdata);
               chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
               if (e.lat >= 0) chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one command and waits (bounded) for acceptance; expectations come from the model.
   task automatic push(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int w, input int lat);
      bit   rdy;
      int   n;
      int   idx;
      exp_t e;
      rdy = 0;
      n   = 0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      do begin
         @(negedge clk);
         rdy = cmd_ready_o;
         @(posedge clk);
         n++;
      end while (!rdy && n < 2000);
      #1;
      cmd_valid = 1'b0;
      if (!rdy) begin
         fail("push_accept_timeout");
         return;
      end
      idx       = int'(addr[5:2]);
      e.wr      = wr;
      e.addr    = addr;
      e.wdata   = data;
      e.err     = (w > TMO);
      e.rdata   = (e.err || wr) ? 32'h0 : ref_mem[idx];
      e.acc_cyc = cyc;
      e.lat     = lat;
      if (wr && !e.err) ref_mem[idx] = data;
      rsp_q.push_back(e);
      setup_q.push_back(e);
      wait_q.push_back(w);
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while ((rsp_q.size() > 0 || setup_q.size() > 0) && n < maxc) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (rsp_q.size() > 0 || setup_q.size() > 0) fail("drain_timeout");
      tick();
   endtask

   initial begin
      int c0;
      int n;
      int r;
      int w;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_psel", 32'(psel_o), 0);
      chk("reset_penable", 32'(penable_o), 0);
      chk("reset_rsp_valid", 32'(rsp_valid_o), 0);
      chk("reset_paddr", paddr_o, 0);
      chk("reset_cmd_ready", 32'(cmd_ready_o), 1);
      @(negedge clk);
      rst_ = 1'b1;
      tick();

      // Single zero-wait write: setup/access/response timing
      push(1'b1, 32'h0C, 32'h0000_00A5, 0, 3);
      chk("wr_psel_e0", 32'(psel_o), 0);
      tick();
      chk("wr_psel_e1", 32'(psel_o), 1);
      chk("wr_penable_e1", 32'(penable_o), 0);
      tick();
      chk("wr_penable_e2", 32'(penable_o), 1);
      drain(20);

      // Read with two wait states
      push(1'b0, 32'h04, 32'h0, 2, 5);
      tick();
      tick();
      repeat (3) begin
         chk("rd_penable_held", 32'(penable_o), 1);
         tick();
      end
      chk("rd_penable_done", 32'(penable_o), 0);
      drain(20);

      // Fill with a stalled bus, then release: order and continuous psel
      c0 = cyc;
      push(1'b1, 32'h10, $urandom, 10, -1);
      for (int i = 0; i < 4; i++) push(i[0], 32'(4 * (i + 5)), $urandom, 0, -1);
      chk("full_consecutive_accepts", 32'(cyc - c0), 5);
      chk("full_cmd_ready_low", 32'(cmd_ready_o), 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid_o && n < 100);
      if (!rsp_valid_o) fail("full_first_rsp_timeout");
      else chk("full_ready_after_pop", 32'(cmd_ready_o), 1);
      drain(100);
      chk("b2b_psel_run", 32'(last_run), 20);

      // Push and pop on the same edge at count 3
      push(1'b0, 32'h20, 32'h0, 1, -1);
      push(1'b1, 32'h24, $urandom, 0, -1);
      push(1'b0, 32'h28, 32'h0, 0, -1);
      push(1'b1, 32'h2C, $urandom, 0, -1);
      push(1'b0, 32'h30, 32'h0, 0, -1);
      chk("pushpop_ready_cnt3", 32'(cmd_ready_o), 1);
      push(1'b0, 32'h34, 32'h0, 0, -1);
      chk("pushpop_ready_cnt4", 32'(cmd_ready_o), 0);
      drain(100);

      // Timeout with a stuck slave, next command proceeds normally
      push(1'b0, 32'h08, 32'h0, STUCK, 2 + TMO + 1);
      push(1'b0, 32'h04, 32'h0, 0, -1);
      drain(600);

      // Reset in the middle of an access with two commands still queued
      push(1'b0, 32'h00, 32'h0, STUCK, -1);
      push(1'b0, 32'h04, 32'h0, 0, -1);
      push(1'b0, 32'h08, 32'h0, 0, -1);
      repeat (5) tick();
      chk("pre_rst_penable", 32'(penable_o), 1);
      @(negedge clk);
      #2;
      rst_ = 1'b0;
      #1;
      chk("rst_psel_async", 32'(psel_o), 0);
      chk("rst_penable_async", 32'(penable_o), 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst_ = 1'b1;
      tick();
      chk("post_rst_cmd_ready", 32'(cmd_ready_o), 1);
      n = 0;
      repeat (6) begin
         if (psel_o || rsp_valid_o) n++;
         tick();
      end
      chk("post_rst_bus_quiet", 32'(n), 0);

      // Randomized traffic
      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 39);
         w = (r == 0) ? STUCK : ((r < 20) ? 0 : $urandom_range(1, 3));
         push(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)), $urandom, w, -1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
      end
      drain(4000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit (t=%0t)", $time);
      $fatal(1, "time limit");
   end

endmodule
